// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage access controller: state encoding,
// default widths and the value returned by aborted accesses.
package mem_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 15;

  // Wide all-ones constant; users slice it down to their data width.
  localparam logic [255:0] ERR_RDATA = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    DONE   = 2'b10,
    UNUSED = 2'b11
  } state_t;

endpackage

// File: rtl/mac_timeout_cnt.sv
// 8-bit bus wait counter. tc flags the enabled cycle whose increment
// makes the count reach limit.
module mac_timeout_cnt (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] limit,
  output logic       tc
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    cnt <= '0;
    else if (clear) cnt <= '0;
    else if (en)    cnt <= cnt + 8'd1;
  end

  assign tc = en && (cnt == limit - 8'd1);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: turns a CPU load/store strobe into a single
// external bus access, stalling the pipeline until it completes or times out.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              mem_force,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  input  logic              err_clr,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic              bus_err,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [1:0]        dbg_state
);

  // Handshake: bus_req holds high with stable we/addr/wdata for the whole
  // BUSY period; a one-cycle bus_ack (bus_err/bus_rdata qualified by it)
  // ends the access. bus_ack outside BUSY is ignored.
  state_t state, state_nxt;
  logic   ack_hit, timeout, abort;

  assign ack_hit = (state == BUSY) && bus_ack;
  assign abort   = (ack_hit && bus_err) || timeout;

  mac_timeout_cnt u_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clear  (state != BUSY),
    .en     ((state == BUSY) && !bus_ack),
    .limit  (8'(TIMEOUT)),
    .tc     (timeout)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_force = 1'b0;
    bus_req   = 1'b0;
    case (state)
      IDLE: if (req_valid) state_nxt = BUSY;
      BUSY: begin
        mem_force = 1'b1;
        bus_req   = 1'b1;
        if (ack_hit || timeout) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch and result registers; the unused encoding scrubs them
  // back to reset values on its way to IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rdata     <= '0;
      err       <= 1'b0;
    end else if (state == UNUSED) begin
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rdata     <= '0;
      err       <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        bus_we    <= req_we;
        bus_addr  <= req_addr;
        bus_wdata <= req_wdata;
      end
      if (abort)                       rdata <= ERR_RDATA[DATA_W-1:0];
      else if (ack_hit && !bus_we)     rdata <= bus_rdata;
      if (abort)        err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus randomized accesses
// checked against a transaction-level model of the controller.
module tb_mem_access_ctrl;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 15;

  // clock/reset
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0, req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          mem_force, err, bus_req, bus_we;
  logic          err_clr = 1'b0;
  logic [DW-1:0] rdata, bus_wdata;
  logic [AW-1:0] bus_addr;
  logic          bus_ack = 1'b0, bus_err = 1'b0;
  logic [DW-1:0] bus_rdata = '0;
  logic [1:0]    dbg_state;

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .mem_force (mem_force),
    .rdata     (rdata),
    .err       (err),
    .err_clr   (err_clr),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_err   (bus_err),
    .bus_rdata (bus_rdata),
    .dbg_state (dbg_state)
  );

  int n_vec = 0;
  int n_bad = 0;

  // reference model: architectural result registers
  logic [DW-1:0] m_rdata = '0;
  logic          m_err   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag, input logic [1:0] exp_state);
    check({tag, "_state"}, dbg_state, exp_state);
    check({tag, "_force"}, mem_force, 0);
    check({tag, "_bus_req"}, bus_req, 0);
    check({tag, "_rdata"}, rdata, m_rdata);
    check({tag, "_err"}, err, m_err);
  endtask

  // One access started in IDLE at a negedge. k = cycle (after the request)
  // on which bus_ack arrives; k outside 1..TO means no ack while busy.
  task automatic access(input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input int k,
                        input logic [DW-1:0] rd, input logic berr,
                        input logic noise, input logic clr_rand);
    int   busy_len;
    logic acked, clr;
    acked    = (k >= 1 && k <= TO);
    busy_len = acked ? k : TO;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    for (int j = 1; j <= busy_len; j++) begin
      check("busy_state", dbg_state, 2'b01);
      check("busy_force", mem_force, 1);
      check("busy_bus_req", bus_req, 1);
      check("busy_bus_we", bus_we, we);
      check("busy_bus_addr", bus_addr, addr);
      check("busy_bus_wdata", bus_wdata, wdata);
      check("busy_rdata", rdata, m_rdata);
      check("busy_err", err, m_err);
      bus_ack   = (j == k);
      bus_err   = berr;
      bus_rdata = (j == k) ? rd : DW'($urandom);
      clr = clr_rand && ($urandom_range(0, 3) == 0);
      err_clr = clr;
      if (noise) begin
        req_valid = 1'($urandom_range(0, 1));
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = AW'($urandom);
        req_wdata = DW'($urandom);
      end
      if (j == busy_len) begin
        if (!acked || berr) begin
          m_err = 1'b1;
          m_rdata = '1;
        end else begin
          if (clr) m_err = 1'b0;
          if (!we) m_rdata = rd;
        end
      end else if (clr) m_err = 1'b0;
      @(negedge clk);
    end
    bus_ack = 1'b0;
    check_quiet("done", 2'b10);
    // DONE cycle: a late ack or a new strobe here must be ignored
    bus_ack   = (k == TO + 1);
    bus_err   = 1'($urandom_range(0, 1));
    bus_rdata = DW'($urandom);
    clr = clr_rand && ($urandom_range(0, 3) == 0);
    err_clr = clr;
    if (clr) m_err = 1'b0;
    if (noise) begin
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = AW'($urandom);
    end
    @(negedge clk);
    bus_ack = 1'b0; req_valid = 1'b0; err_clr = 1'b0;
    check_quiet("idle", 2'b00);
  endtask

  task automatic idle_cycle(input logic stray_ack, input logic clr);
    bus_ack = stray_ack; bus_err = 1'($urandom_range(0, 1)); bus_rdata = DW'($urandom);
    err_clr = clr;
    if (clr) m_err = 1'b0;
    @(negedge clk);
    bus_ack = 1'b0; err_clr = 1'b0;
    check_quiet("gap", 2'b00);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_quiet("reset", 2'b00);
    check("reset_bus_we", bus_we, 0);
    check("reset_bus_addr", bus_addr, 0);
    check("reset_bus_wdata", bus_wdata, 0);
    resetn = 1'b1;
    @(negedge clk);

    // load, ack after 3 cycles
    access(1'b0, 16'h0040, 16'h0000, 3, 16'h1234, 1'b0, 1'b0, 1'b0);
    check("load3_rdata", rdata, 16'h1234);
    check("load3_err", err, 0);
    // store, ack in 1 cycle: rdata untouched
    access(1'b1, 16'h0010, 16'hBEEF, 1, 16'h5555, 1'b0, 1'b0, 1'b0);
    check("store1_rdata", rdata, 16'h1234);
    // timeout, then clear the sticky error
    access(1'b0, 16'h0020, 16'h0000, 0, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("timeout_err", err, 1);
    check("timeout_rdata", rdata, 16'hFFFF);
    idle_cycle(1'b0, 1'b1);
    check("errclr_err", err, 0);
    // ack on the timeout cycle wins
    access(1'b0, 16'h0030, 16'h0000, TO, 16'h00A5, 1'b0, 1'b0, 1'b0);
    check("ack_at_to_rdata", rdata, 16'h00A5);
    check("ack_at_to_err", err, 0);
    // strobes during BUSY/DONE with different addresses are ignored
    access(1'b0, 16'h0050, 16'h0000, 5, 16'h0BAD, 1'b0, 1'b1, 1'b0);

    // reset in the middle of a pending load, then a stale ack
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0080;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_pre_force", mem_force, 1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    m_rdata = '0; m_err = 1'b0;
    check_quiet("rst_mid", 2'b00);
    check("rst_mid_bus_addr", bus_addr, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    idle_cycle(1'b1, 1'b0);

    // randomized accesses with idle gaps carrying stray acks and clears
    for (int n = 0; n < 40; n++) begin
      int k;
      k = (($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO + 1)));
      access(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), k,
             DW'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'b1);
      repeat ($urandom_range(0, 2))
        idle_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width.
REQ-002 SHALL have parameter DATA_W, default 16, data width.
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum bus wait cycles before abort (range 1..255).
REQ-004 SHALL have ports:
  clk  in  1  clock; all state on rising edge
  resetn  in  1  reset, asynchronous, active-low
  req_valid  in  1  CPU access strobe, driven by the stage FSM's EX-to-MEM write enable
  req_we  in  1  1 = store, 0 = load
  req_addr  in  ADDR_W  access address
  req_wdata  in  DATA_W  store data
  mem_force  out  1  stall to stage FSM; high holds CPU in MEM stage
  rdata  out  DATA_W  load result, valid while mem_force low after completion
  err  out  1  sticky access-error flag
  err_clr  in  1  synchronous clear of err
  bus_req  out  1  external bus request
  bus_we  out  1  external write enable
  bus_addr  out  ADDR_W  external address
  bus_wdata  out  DATA_W  external write data
  bus_ack  in  1  external completion, one-cycle pulse
  bus_err  in  1  external error, qualified by bus_ack
  bus_rdata  in  DATA_W  external read data, valid with bus_ack

Function
REQ-005 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-006 IDLE: on req_valid=1, SHALL latch req_we/req_addr/req_wdata and enter BUSY next cycle; otherwise stay IDLE.
REQ-007 BUSY: bus_req=1 and bus_we/bus_addr/bus_wdata SHALL equal the latched values, stable for the whole BUSY period.
REQ-008 BUSY: on bus_ack=1, SHALL enter DONE; if load and bus_err=0, rdata SHALL take bus_rdata at that edge.
REQ-009 BUSY: wait counter SHALL start at 0 on BUSY entry and increment each BUSY cycle without bus_ack; when it reaches TIMEOUT, SHALL enter DONE with timeout abort.
REQ-010 bus_ack and timeout in the same cycle: bus_ack SHALL win; no error from timeout.
REQ-011 Abort (timeout, or bus_ack with bus_err=1): err SHALL be set to 1 and rdata SHALL be all-ones.
REQ-012 DONE: SHALL last exactly one cycle, then enter IDLE.
REQ-013 mem_force SHALL be 1 exactly when state is BUSY (registered-state decode, no combinational path from bus_ack).
REQ-014 Latency: req_valid at cycle T, bus_ack at T+k (k>=1) -> mem_force high T+1..T+k, low at T+k+1 (DONE).
REQ-015 Stores SHALL leave rdata unchanged unless aborted.
REQ-016 rdata SHALL hold its value in IDLE and DONE.
REQ-017 req_valid in BUSY or DONE SHALL be ignored (no relatch, no state change).
REQ-018 bus_ack in IDLE or DONE SHALL be ignored.
REQ-019 err SHALL be sticky; err_clr=1 clears it; err_clr and a new abort in the same cycle -> err=1.
REQ-020 bus_req SHALL be 0 in IDLE and DONE; at most one outstanding bus access.

Reset
REQ-021 resetn=0 SHALL immediately force state IDLE, bus_req=0, mem_force=0, err=0, rdata=0, bus_we=0, bus_addr=0, bus_wdata=0, wait counter=0.
REQ-022 Reset mid-BUSY SHALL abandon the access; a later bus_ack for it SHALL be ignored.

Structure
REQ-023 Shared package mem_pkg SHALL hold the state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10), default widths, TIMEOUT default and the ERR_RDATA all-ones constant.
REQ-024 Wait counter SHALL be a sub-module mac_timeout_cnt (clear, enable, terminal-count output, 8-bit).
REQ-025 Unused state encoding (2'b11) SHALL transition to IDLE with all outputs at reset values.

Verification
REQ-026 Load, ack after 3 cycles: req_valid T, addr 0x0040, bus_rdata 0x1234 at T+3 -> mem_force high T+1..T+3, low T+4, rdata=0x1234, err=0.
REQ-027 Store, ack in 1 cycle: req_we=1, addr 0x0010, wdata 0xBEEF -> bus_we=1, bus_wdata=0xBEEF at T+1, mem_force high only at T+1, rdata unchanged.
REQ-028 Timeout: no bus_ack -> mem_force high 15 cycles, DONE at T+16, err=1, rdata=0xFFFF; err_clr pulse -> err=0.
REQ-029 bus_ack coincident with timeout cycle, bus_rdata 0x00A5 -> rdata=0x00A5, err=0.
REQ-030 Reset asserted at T+2 of a pending load -> bus_req and mem_force 0 immediately; stale bus_ack after release ignored, state IDLE.
REQ-031 req_valid re-pulsed during BUSY with different addr -> bus_addr unchanged, single bus access completes normally.
